arbitro_escrita_registradores: RTL and testbench

- Shares the single write port of the 32x32 register bank between two writeback requesters: A (ALU result path) and B (load/multicycle unit).
- Uses a valid/ready handshake, round-robin priority and a registered output stage that drives the bank's escrever_registrador, registrador_escrita and dados_escrita directly.
- Provides a pending-write query for hazard logic and a saturating contention counter for performance debug.

---
 rtl/arbitro_escrita_registradores_if.sv | 34 +++
 rtl/arbitro_escrita_registradores.sv | 109 ++++++++++
 tb/tb_arbitro_escrita_registradores.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_escrita_registradores_if.sv
// Write-port bundle between the two writeback requesters and the arbiter,
// plus the registered write port that feeds the 32x32 register bank.
interface arbitro_escrita_registradores_if #(
    parameter int LARGURA_DADOS    = 32,
    parameter int LARGURA_ENDERECO = 5
);
    logic                        req_a_valido;
    logic [LARGURA_ENDERECO-1:0] req_a_registrador;
    logic [LARGURA_DADOS-1:0]    req_a_dados;
    logic                        req_a_pronto;

    logic                        req_b_valido;
    logic [LARGURA_ENDERECO-1:0] req_b_registrador;
    logic [LARGURA_DADOS-1:0]    req_b_dados;
    logic                        req_b_pronto;

    logic                        escrever_registrador;
    logic [LARGURA_ENDERECO-1:0] registrador_escrita;
    logic [LARGURA_DADOS-1:0]    dados_escrita;

    modport master (
        output req_a_valido, req_a_registrador, req_a_dados,
        output req_b_valido, req_b_registrador, req_b_dados,
        input  req_a_pronto, req_b_pronto,
        input  escrever_registrador, registrador_escrita, dados_escrita
    );

    modport slave (
        input  req_a_valido, req_a_registrador, req_a_dados,
        input  req_b_valido, req_b_registrador, req_b_dados,
        output req_a_pronto, req_b_pronto,
        output escrever_registrador, registrador_escrita, dados_escrita
    );
endinterface

// File: rtl/arbitro_escrita_registradores.sv
// Round-robin arbiter sharing the register bank write port between the ALU (A)
// and load/multicycle (B) writeback paths, with a one-cycle registered output.
module arbitro_escrita_registradores #(
    parameter int LARGURA_DADOS    = 32,
    parameter int LARGURA_ENDERECO = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    arbitro_escrita_registradores_if.slave bus,
    input  logic [LARGURA_ENDERECO-1:0] consulta_registrador,
    output logic                        consulta_pendente,
    output logic [7:0]                  contador_conflitos
);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prioridade_t;

    prioridade_t                 r_prio;
    prioridade_t                 w_prio_next;
    logic                        w_pronto_a;
    logic                        w_pronto_b;
    logic                        w_conflito;
    logic [LARGURA_ENDERECO-1:0] w_sel_registrador;
    logic [LARGURA_DADOS-1:0]    w_sel_dados;

    logic                        r_escrever_p1;
    logic [LARGURA_ENDERECO-1:0] r_registrador_p1;
    logic [LARGURA_DADOS-1:0]    r_dados_p1;
    logic [7:0]                  r_conflitos;

    function automatic logic [7:0] incremento_saturado(input logic [7:0] valor);
        return (valor == 8'hFF) ? valor : valor + 8'd1;
    endfunction

    // Stage p0: grant decision and priority update, combinational from valids
    always_comb begin
        w_pronto_a  = 1'b0;
        w_pronto_b  = 1'b0;
        w_prio_next = r_prio;
        if (!reset) begin
            if (bus.req_a_valido && (!bus.req_b_valido || r_prio == PRIO_A)) begin
                w_pronto_a = 1'b1;
            end else if (bus.req_b_valido) begin
                w_pronto_b = 1'b1;
            end
        end
        if (w_pronto_a) begin
            w_prio_next = PRIO_B;
        end else if (w_pronto_b) begin
            w_prio_next = PRIO_A;
        end
    end

    always_comb begin
        w_sel_registrador = bus.req_b_registrador;
        w_sel_dados       = bus.req_b_dados;
        if (w_pronto_a) begin
            w_sel_registrador = bus.req_a_registrador;
            w_sel_dados       = bus.req_a_dados;
        end
    end

    assign w_conflito = bus.req_a_valido && bus.req_b_valido;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= PRIO_A;
        end else begin
            r_prio <= w_prio_next;
        end
    end

    // Stage p1: registered write port; writes to x0 are accepted but never enabled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_escrever_p1    <= 1'b0;
            r_registrador_p1 <= '0;
            r_dados_p1       <= '0;
        end else if (w_pronto_a || w_pronto_b) begin
            r_escrever_p1    <= (w_sel_registrador != '0);
            r_registrador_p1 <= w_sel_registrador;
            r_dados_p1       <= w_sel_dados;
        end else begin
            r_escrever_p1    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_conflitos <= 8'd0;
        end else if (w_conflito) begin
            r_conflitos <= incremento_saturado(r_conflitos);
        end
    end

    assign bus.req_a_pronto         = w_pronto_a;
    assign bus.req_b_pronto         = w_pronto_b;
    assign bus.escrever_registrador = r_escrever_p1;
    assign bus.registrador_escrita  = r_registrador_p1;
    assign bus.dados_escrita        = r_dados_p1;

    assign consulta_pendente  = r_escrever_p1
                                && (r_registrador_p1 == consulta_registrador)
                                && (consulta_registrador != '0);
    assign contador_conflitos = r_conflitos;

endmodule

// File: tb/tb_arbitro_escrita_registradores.sv
// Directed bench for the register-bank write arbiter with a write scoreboard.
module tb_arbitro_escrita_registradores;

    logic       clk;
    logic       reset;
    logic [4:0] consulta_registrador;
    logic       consulta_pendente;
    logic [7:0] contador_conflitos;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t q_exp[$];
    wr_t mon_e;

    arbitro_escrita_registradores_if #(.LARGURA_DADOS(32), .LARGURA_ENDERECO(5)) bus ();

    arbitro_escrita_registradores #(.LARGURA_DADOS(32), .LARGURA_ENDERECO(5)) dut (
        .clk                  (clk),
        .reset                (reset),
        .bus                  (bus),
        .consulta_registrador (consulta_registrador),
        .consulta_pendente    (consulta_pendente),
        .contador_conflitos   (contador_conflitos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every enabled bank write must match the oldest expected write
    always @(posedge clk) begin
        #1;
        if (bus.escrever_registrador === 1'b1) begin
            if (q_exp.size() == 0) begin
                chk(1'b0, "unexpected_write", {27'b0, bus.registrador_escrita, bus.dados_escrita}, 64'h0);
            end else begin
                mon_e = q_exp.pop_front();
                chk((bus.registrador_escrita == mon_e.r) && (bus.dados_escrita == mon_e.d), "bank_write",
                    {27'b0, bus.registrador_escrita, bus.dados_escrita}, {27'b0, mon_e.r, mon_e.d});
            end
        end
    end

    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic ea, input logic eb);
        wr_t e;
        @(negedge clk);
        reset                 = 1'b0;
        bus.req_a_valido      = av;
        bus.req_a_registrador = ar;
        bus.req_a_dados       = ad;
        bus.req_b_valido      = bv;
        bus.req_b_registrador = br;
        bus.req_b_dados       = bd;
        #1;
        chk(bus.req_a_pronto === ea, "req_a_pronto", {63'b0, bus.req_a_pronto}, {63'b0, ea});
        chk(bus.req_b_pronto === eb, "req_b_pronto", {63'b0, bus.req_b_pronto}, {63'b0, eb});
        if (ea && ar != 5'd0) begin
            e.r = ar; e.d = ad; q_exp.push_back(e);
        end
        if (eb && br != 5'd0) begin
            e.r = br; e.d = bd; q_exp.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        reset            = 1'b0;
        bus.req_a_valido = 1'b0;
        bus.req_b_valido = 1'b0;
        #1;
    endtask

    task automatic do_reset(input int n, input logic valids);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset                 = 1'b1;
            bus.req_a_valido      = valids;
            bus.req_a_registrador = 5'd1;
            bus.req_a_dados       = 32'hDEAD0001;
            bus.req_b_valido      = valids;
            bus.req_b_registrador = 5'd2;
            bus.req_b_dados       = 32'hDEAD0002;
            #1;
            chk(bus.req_a_pronto === 1'b0, "reset_pronto_a", {63'b0, bus.req_a_pronto}, 64'h0);
            chk(bus.req_b_pronto === 1'b0, "reset_pronto_b", {63'b0, bus.req_b_pronto}, 64'h0);
        end
    endtask

    task automatic pend_check(input logic [4:0] idx, input logic exp);
        consulta_registrador = idx;
        #1;
        chk(consulta_pendente === exp, $sformatf("consulta_pendente_x%0d", idx), {63'b0, consulta_pendente}, {63'b0, exp});
    endtask

    task automatic cnt_check(input logic [7:0] exp);
        chk(contador_conflitos === exp, "contador_conflitos", {56'b0, contador_conflitos}, {56'b0, exp});
    endtask

    task automatic wen_check(input logic exp);
        chk(bus.escrever_registrador === exp, "escrever_registrador", {63'b0, bus.escrever_registrador}, {63'b0, exp});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks              = 0;
        n_errors              = 0;
        reset                 = 1'b1;
        consulta_registrador  = 5'd0;
        bus.req_a_valido      = 1'b0;
        bus.req_a_registrador = 5'd0;
        bus.req_a_dados       = 32'h0;
        bus.req_b_valido      = 1'b0;
        bus.req_b_registrador = 5'd0;
        bus.req_b_dados       = 32'h0;

        // 1: reset, no requests
        do_reset(2, 1'b0);
        idle();
        wen_check(1'b0);
        cnt_check(8'd0);
        for (int i = 0; i < 32; i++) pend_check(i[4:0], 1'b0);

        // 2: A only, x5
        cycle(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        idle();
        wen_check(1'b1);
        pend_check(5'd5, 1'b1);
        pend_check(5'd6, 1'b0);

        // 3: contention after reset, A first then B
        do_reset(1, 1'b0);
        cycle(1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd4, 32'h0000BBBB, 1'b1, 1'b0);
        cycle(1'b0, 5'd3, 32'h0000AAAA, 1'b1, 5'd4, 32'h0000BBBB, 1'b0, 1'b1);
        idle();
        cnt_check(8'd1);

        // 4: sustained contention alternates A,B,A,B; then same destination x7
        do_reset(1, 1'b0);
        cycle(1'b1, 5'd8,  32'hA0000001, 1'b1, 5'd9,  32'hB0000001, 1'b1, 1'b0);
        cycle(1'b1, 5'd10, 32'hA0000002, 1'b1, 5'd9,  32'hB0000001, 1'b0, 1'b1);
        cycle(1'b1, 5'd10, 32'hA0000002, 1'b1, 5'd11, 32'hB0000002, 1'b1, 1'b0);
        cycle(1'b1, 5'd12, 32'hA0000003, 1'b1, 5'd11, 32'hB0000002, 1'b0, 1'b1);
        idle();
        cnt_check(8'd4);
        cycle(1'b1, 5'd7, 32'h00000001, 1'b1, 5'd7, 32'h00000002, 1'b1, 1'b0);
        cycle(1'b0, 5'd7, 32'h00000001, 1'b1, 5'd7, 32'h00000002, 1'b0, 1'b1);
        idle();
        pend_check(5'd7, 1'b1);

        // 5: B writes x0, dropped at the bank; pointer returns to A
        do_reset(1, 1'b0);
        cycle(1'b1, 5'd10, 32'h00001010, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1);
        idle();
        wen_check(1'b0);
        pend_check(5'd0, 1'b0);
        cycle(1'b1, 5'd11, 32'h00001111, 1'b1, 5'd12, 32'h00001212, 1'b1, 1'b0);
        cycle(1'b0, 5'd11, 32'h00001111, 1'b1, 5'd12, 32'h00001212, 1'b0, 1'b1);

        // 6: reset right after an A acceptance
        do_reset(1, 1'b0);
        cycle(1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        do_reset(1, 1'b1);
        idle();
        wen_check(1'b0);
        cnt_check(8'd0);
        cycle(1'b1, 5'd13, 32'h13131313, 1'b1, 5'd14, 32'h14141414, 1'b1, 1'b0);
        idle();
        cnt_check(8'd1);

        // 6b: 300 contended cycles saturate the counter
        do_reset(2, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 5'd1, 32'hA000_0000 + i, 1'b1, 5'd2, 32'hB000_0000 + i,
                  (i % 2) == 0, (i % 2) == 1);
        end
        idle();
        cnt_check(8'd255);

        idle();
        idle();
        chk(q_exp.size() == 0, "writes_outstanding", q_exp.size(), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
